// File: rtl/ex_div_sequencer_pkg.sv
// Shared types and constants for the EX-stage multi-cycle divider.
// Holds the ALU opcode space, the divider FSM encoding and op-class helpers.
package ex_div_sequencer_pkg;

  typedef logic [31:0] DType;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_LUI   = 5'd10,
    ALU_MUL   = 5'd11,
    ALU_MULH  = 5'd12,
    ALU_MULHU = 5'd13,
    ALU_DIV   = 5'd14,
    ALU_MOD   = 5'd15,
    ALU_DIVU  = 5'd16,
    ALU_MODU  = 5'd17
  } AluCtrl;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } DivState;

  typedef union packed {
    DivState    state;
    logic [2:0] bits;
  } DivStateBit;

  parameter int   DIV_ITERS    = 32;
  parameter DType DIV_ZERO_QUO = 32'hFFFF_FFFF;
  localparam int  CNT_W        = $clog2(DIV_ITERS);

  function automatic logic isDivOp(input logic [4:0] op);
    return (op inside {ALU_DIV, ALU_MOD, ALU_DIVU, ALU_MODU});
  endfunction

  function automatic logic isSignedOp(input logic [4:0] op);
    return (op inside {ALU_DIV, ALU_MOD});
  endfunction

  function automatic logic isModOp(input logic [4:0] op);
    return (op inside {ALU_MOD, ALU_MODU});
  endfunction

  // Two's-complement negate when neg is set; maps 0x80000000 onto itself,
  // which is exactly the 2^31 magnitude the unsigned datapath needs.
  function automatic DType negIf(input DType x, input logic neg);
    return neg ? DType'(-x) : x;
  endfunction

endpackage

// File: rtl/ex_div_sequencer_if.sv
// EX-stage <-> divider bundle: request side driven by the pipeline,
// stall/done/result returned by the divider.
interface ex_div_sequencer_if;
  import ex_div_sequencer_pkg::*;

  logic       start;
  logic [4:0] op;
  DType       src1;
  DType       src2;
  logic       flush;
  logic       stall;
  logic       done;
  DType       result;

  modport master (
    output start, op, src1, src2, flush,
    input  stall, done, result
  );

  modport slave (
    input  start, op, src1, src2, flush,
    output stall, done, result
  );

endinterface

// File: rtl/ex_div_sequencer_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module ex_div_sequencer_div_step
  import ex_div_sequencer_pkg::*;
(
  input  DType rem_i,
  input  DType quo_i,
  input  DType divisor_i,
  output DType rem_o,
  output DType quo_o
);

  logic [32:0] shifted;
  logic        fits;

  // The shifted remainder can reach 33 bits; once it fits under the divisor
  // the difference is below 2^32, so the 32-bit subtract is exact.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    fits    = (shifted >= {1'b0, divisor_i});
    rem_o   = fits ? (shifted[31:0] - divisor_i) : shifted[31:0];
    quo_o   = {quo_i[30:0], fits};
  end

endmodule

// File: rtl/ex_div_sequencer.sv
// Multi-cycle divide/modulo sequencer for EX: stalls the front end while a
// 32-step restoring division runs, then presents a one-cycle result.
module ex_div_sequencer
  import ex_div_sequencer_pkg::*;
(
  input  logic               aclk,
  input  logic               aresetn,
  ex_div_sequencer_if.slave  bus
);

  DivState          state_q, state_d;
  logic [4:0]       op_q, op_d;
  DType             src1_q, src1_d;
  DType             src2_q, src2_d;
  DType             rem_q, rem_d;
  DType             quo_q, quo_d;
  DType             divisor_q, divisor_d;
  DType             result_q, result_d;
  logic             sign1_q, sign1_d;
  logic             sign2_q, sign2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic startEff;
  logic prepSign1;
  logic prepSign2;
  DType stepRem;
  DType stepQuo;

  assign startEff  = bus.start & isDivOp(bus.op) & ~bus.flush;
  assign prepSign1 = isSignedOp(op_q) & src1_q[31];
  assign prepSign2 = isSignedOp(op_q) & src2_q[31];

  ex_div_sequencer_div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (stepRem),
    .quo_o     (stepQuo)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (startEff) begin
          op_d    = bus.op;
          src1_d  = bus.src1;
          src2_d  = bus.src2;
          state_d = DIV_PREP;
        end
      end
      DIV_PREP: begin
        sign1_d   = prepSign1;
        sign2_d   = prepSign2;
        quo_d     = negIf(src1_q, prepSign1);
        rem_d     = '0;
        divisor_d = negIf(src2_q, prepSign2);
        cnt_d     = CNT_W'(DIV_ITERS - 1);
        // A zero divisor bypasses the iterations with the architected result.
        if (src2_q == '0) begin
          result_d = isModOp(op_q) ? src1_q : DIV_ZERO_QUO;
          state_d  = DIV_DONE;
        end else begin
          state_d  = DIV_ITER;
        end
      end
      DIV_ITER: begin
        rem_d = stepRem;
        quo_d = stepQuo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        result_d = isModOp(op_q) ? negIf(rem_q, sign1_q)
                                 : negIf(quo_q, sign1_q ^ sign2_q);
        state_d  = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    if (bus.flush) begin
      state_d = DIV_IDLE;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= DIV_IDLE;
      op_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, since the reset is only
  // seen by the state register at the next edge.
  always_comb begin
    bus.stall  = aresetn & ~bus.flush &
                 (((state_q == DIV_IDLE) & startEff) |
                  (state_q inside {DIV_PREP, DIV_ITER, DIV_FIX}));
    bus.done   = aresetn & ~bus.flush & (state_q == DIV_DONE);
    bus.result = (aresetn && state_q == DIV_DONE) ? result_q : '0;
  end

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Self-checking bench for ex_div_sequencer: directed corner cases plus
// randomized back-to-back divides against an arithmetic reference.
module tb_ex_div_sequencer;
  import ex_div_sequencer_pkg::*;

  logic aclk = 1'b0;
  logic aresetn;
  int   total = 0;
  int   bad = 0;

  ex_div_sequencer_if bus ();

  ex_div_sequencer dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: plain 64-bit arithmetic on the architected operand values.
  function automatic logic [31:0] refDiv(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic   sgn, isMod;
    sgn   = (op == ALU_DIV) || (op == ALU_MOD);
    isMod = (op == ALU_MOD) || (op == ALU_MODU);
    if (b == 32'h0) return isMod ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return isMod ? r[31:0] : q[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [4:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic f);
    bus.start = s;
    bus.op    = o;
    bus.src1  = a;
    bus.src2  = b;
    bus.flush = f;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, ALU_ADD, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic expStall, input logic expDone,
                             input logic [31:0] expResult);
    @(negedge aclk);
    check($sformatf("%s.stall", tag), {31'b0, bus.stall}, {31'b0, expStall});
    check($sformatf("%s.done", tag), {31'b0, bus.done}, {31'b0, expDone});
    check($sformatf("%s.result", tag), bus.result, expResult);
  endtask

  // Starts a divide in the current cycle and holds it until done; on return
  // the bench sits just after the edge that ends the done cycle.
  task automatic runDiv(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int          expLat;
    int          stallCnt;
    int          doneCyc;
    int          cyc;
    logic [31:0] res;
    logic        stray;
    expLat   = (b == 32'h0) ? 2 : 35;
    stallCnt = 0;
    doneCyc  = -1;
    cyc      = 0;
    res      = 32'h0;
    stray    = 1'b0;
    applyStimulus(1'b1, op, a, b, 1'b0);
    while (cyc < 60 && doneCyc < 0) begin
      @(negedge aclk);
      if (bus.stall === 1'b1) stallCnt++;
      if (bus.done === 1'b1) begin
        doneCyc = cyc;
        res     = bus.result;
      end else if (bus.result !== 32'h0) begin
        stray = 1'b1;
      end
      nextCycle();
      if (cyc == 0) begin
        bus.src1 = $urandom;
        bus.src2 = $urandom;
      end
      cyc++;
    end
    check($sformatf("%s.doneCycle", tag), doneCyc, expLat);
    check($sformatf("%s.stallCycles", tag), stallCnt, expLat);
    check($sformatf("%s.result", tag), res, exp);
    check($sformatf("%s.resultIdleZero", tag), {31'b0, stray}, 32'h0);
  endtask

  logic [4:0]  divOps [4] = '{ALU_DIV, ALU_MOD, ALU_DIVU, ALU_MODU};
  logic [4:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    aresetn = 1'b0;
    applyStimulus(1'b1, ALU_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
    checkOutput("resetHeld0", 1'b0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("resetHeld1", 1'b0, 1'b0, 32'h0);
    nextCycle();
    aresetn = 1'b1;
    idleBus();
    checkOutput("idleAfterReset", 1'b0, 1'b0, 32'h0);
    nextCycle();

    runDiv(ALU_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "divNeg7by2");
    runDiv(ALU_MOD,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "modNeg7by2");
    runDiv(ALU_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, "divuMax16");
    runDiv(ALU_MODU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, "moduMax16");
    runDiv(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divOverflow");
    runDiv(ALU_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "modOverflow");
    runDiv(ALU_DIV,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divByZero");
    runDiv(ALU_MOD,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "modByZero");
    idleBus();
    checkOutput("donePulseEnds", 1'b0, 1'b0, 32'h0);
    nextCycle();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? ALU_ADD : ALU_MUL, $urandom, $urandom, 1'b0);
      checkOutput($sformatf("nonDiv%0d", i), 1'b0, 1'b0, 32'h0);
      nextCycle();
    end

    applyStimulus(1'b1, ALU_DIVU, $urandom, 32'h0000_0003, 1'b0);
    repeat (10) nextCycle();
    bus.flush = 1'b1;
    checkOutput("flushCycle", 1'b0, 1'b0, 32'h0);
    nextCycle();
    idleBus();
    checkOutput("afterFlush", 1'b0, 1'b0, 32'h0);
    nextCycle();
    runDiv(ALU_DIVU, 32'd100, 32'd7, 32'd14, "divuAfterFlush");

    applyStimulus(1'b1, ALU_DIV, $urandom, 32'h0000_0009, 1'b0);
    repeat (20) nextCycle();
    aresetn = 1'b0;
    checkOutput("midReset", 1'b0, 1'b0, 32'h0);
    nextCycle();
    aresetn = 1'b1;
    idleBus();
    checkOutput("afterMidReset", 1'b0, 1'b0, 32'h0);
    nextCycle();
    runDiv(ALU_DIV, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, "divAfterReset");

    for (int i = 0; i < 16; i++) begin
      rop = divOps[$urandom_range(0, 3)];
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 15);
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'h0 - $urandom_range(1, 9);
        4: ra = $urandom_range(0, 50);
        default: ;
      endcase
      runDiv(rop, ra, rb, refDiv(rop, ra, rb), $sformatf("rand%0d", i));
    end
    idleBus();
    checkOutput("finalIdle", 1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_div_sequencer.md
# ex_div_sequencer

Multi-cycle integer divide unit for the EX stage. It accepts ALU_DIV, ALU_MOD, ALU_DIVU and ALU_MODU operations and runs a radix-2 restoring division over 32 iterations. While the division is in progress it stalls IF/ID/EX, then hands a single-cycle result to the EX/MEM boundary. The single-cycle ALU keeps every other AluCtrl operation.

## Interface
- No parameters; data width is fixed at 32 (DType).
- aclk  in  1  system clock; all state updates on rising edge
- aresetn  in  1  reset, synchronous, active-low
- start  in  1  EX stage holds a valid instruction requesting the divider; stays high while stalled
- op  in  5  AluCtrl of the EX instruction; only the four div-class codes are acted on
- src1  in  32  dividend (rj)
- src2  in  32  divisor (rk)
- flush  in  1  pipeline flush (branch redirect); aborts any operation
- stall  out  1  hold PC, IF/ID and ID/EX registers this cycle
- done  out  1  one-cycle pulse; result valid this cycle
- result  out  32  quotient (DIV/DIVU) or remainder (MOD/MODU)

## Operation
- start_eff = start & (op ∈ {ALU_DIV, ALU_MOD, ALU_DIVU, ALU_MODU}) & ~flush. Non-div ops never stall.
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- **IDLE**
  - start_eff → PREP.
  - On that edge, latch op and src1/src2. Operands need not stay stable afterwards.
- **PREP**
  - Record the signs: signed ops use the operand MSBs, unsigned ops use 0.
  - Load |src1| into the quotient/shift register, clear the partial remainder, load |src2| as the divisor, and load the counter with 31.
  - If the divisor is 0, go directly to DONE with the bypass result. Otherwise go to ITER.
- **ITER**
  - One restoring step per cycle: shift {rem,quo} left 1, trial-subtract the divisor, set the quotient LSB if the result is non-negative.
  - The counter decrements each step. When the counter is 0 at the edge → FIX. Exactly 32 ITER cycles.
- **FIX**
  - Quotient is negated if the latched signs differ.
  - Remainder takes the dividend's sign.
  - The result mux selects by the latched op. → DONE.
- **DONE**
  - done=1, stall=0, result driven. → IDLE unconditionally.
  - start is ignored in DONE, because the instruction leaves EX this cycle.
- **Arithmetic rules**
  - Division truncates toward zero.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = src1 (raw), for both signed and unsigned.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of unsigned-magnitude math without a special case.
- **flush**
  - Highest priority after reset. In any state it forces → IDLE next edge with no done pulse.
  - stall is 0 in any cycle where flush=1.
- **Reset** (aresetn=0 at an edge): state IDLE, counter 0, internal registers 0. While aresetn is low, stall=0, done=0 and result=0.
- result is 0 in every state except DONE.

## Timing
- stall is combinational: (state==IDLE & start_eff) | state ∈ {PREP, ITER, FIX}.
- Normal divide, start_eff first seen in IDLE at cycle 0:
  - PREP at cycle 1, ITER cycles 2–33, FIX at 34, DONE at 35.
  - stall is high in cycles 0–34 (35 cycles). done and result are valid in cycle 35.
- Divide by zero: PREP at cycle 1, DONE at cycle 2. stall is high in cycles 0–1.
- Back-to-back divides: the second instruction reaches EX in the cycle after DONE, sees IDLE, and starts with no bubble beyond its own latency.
- Reset mid-operation: IDLE takes effect on the next edge, with no done pulse.

## Structure
- Add to cpuDefine:
  - typedef enum logic [2:0] DivState {DIV_IDLE, DIV_PREP, DIV_ITER, DIV_FIX, DIV_DONE}, with the matching packed union DivStateBit
  - parameter int DIV_ITERS = 32
  - parameter DType DIV_ZERO_QUO = 32'hFFFF_FFFF
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in the sequencer.

## Test plan
- DIV with src1=-7 (0xFFFFFFF9), src2=2: stall high for 35 cycles, then done pulse with result 0xFFFFFFFD (-3). MOD with the same operands gives 0xFFFFFFFF (-1).
- DIVU with src1=0xFFFFFFFF, src2=0x10: result 0x0FFFFFFF at cycle 35. MODU with the same operands gives 0x0000000F.
- DIV with src1=0x80000000, src2=0xFFFFFFFF: result 0x80000000. MOD with the same operands gives 0.
- DIV with src1=5, src2=0: done at cycle 2 with result 0xFFFFFFFF. MOD with src1=5, src2=0: result 5 at cycle 2.
- flush asserted at cycle 10 of a DIVU: stall=0 in that cycle, IDLE at cycle 11, no done pulse. A new DIVU 100/7 started at cycle 12 returns 14 at cycle 47.
- aresetn low for one edge at cycle 20 of a DIV: stall=0, done=0 and result=0 while low, IDLE afterwards. start with op=ALU_ADD never raises stall.
